token_divider: RTL and testbench
================================

Name: token_divider

Overview:
Multi-channel serial token rate reducer, the generalised successor of the fixed halving block. Each channel passes one out of every K incoming '1' tokens. K (the divisor) and the pass phase are runtime-programmable per channel. The block sits between token producers and rate-limited consumers. With K=2 and LAST mode it is bit-exact with the halving behaviour.

Parameters:
N_CH, 4, number of independent token channels (1..16)
DIV_W, 4, divisor and counter width; divisor range 0..2**DIV_W-1
DEF_DIV, 2, per-channel divisor loaded at reset
CH_W, $clog2(N_CH) min 1, channel-select width (localparam)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset; one clock; synchronous, active-low
en  in  1  global enable; 0 = tokens ignored, counters hold
a  in  N_CH  incoming token per channel (1 = token this cycle)
b  out  N_CH  passed token per channel, combinational from a and state
cfg_we  in  1  config write strobe, single cycle
cfg_ch  in  CH_W  channel to configure
cfg_div  in  DIV_W  new divisor K
cfg_mode  in  1  0 = MODE_LAST (pass K-th token of group), 1 = MODE_FIRST (pass 1st token of group)
cnt_o  out  N_CH*DIV_W  per-channel token count within current group (debug/status)

Behaviour:
- Per-channel state: div[DIV_W], mode, cnt[DIV_W]. Reset (rst_n=0 at edge): div=DEF_DIV, mode=MODE_LAST, cnt=0. rst_n overrides cfg_we and a in the same cycle.
- b is combinational, same cycle as the token (zero latency). No output register.
- b[i] = en & a[i] & (div!=0) & hit, where hit = (cnt==div-1) in MODE_LAST and (cnt==0) in MODE_FIRST.
- Counter update at the edge, when en & a[i] & div!=0: cnt <= (cnt==div-1) ? 0 : cnt+1. Otherwise cnt holds.
- div=0: channel blocked. b[i]=0 always and cnt holds.
- div=1: every token passes in both modes. cnt stays 0.
- a[i]=0 cycles never change cnt; gaps of any length preserve the group position.
- Config write (cfg_we=1, cfg_ch<N_CH): at the edge, div<=cfg_div, mode<=cfg_mode, cnt<=0 for that channel only.
- Write with cfg_ch>=N_CH: ignored, no state change.
- Write and token on the same channel in the same cycle: b uses the OLD div/mode/cnt. The token is NOT counted; after the edge cnt=0 under the new config.
- en=0: all b=0 and all counters hold. Config writes are still accepted.
- Channels are fully independent. A write to channel j never disturbs any other channel's cnt.
- Counter never exceeds div-1. If div was reduced by a write, cnt is cleared by that same write, so cnt>=div cannot occur.
- cnt_o[i*DIV_W +: DIV_W] = cnt of channel i (registered value).

Decomposition:
- Package token_div_pkg: typedef enum logic {MODE_LAST, MODE_FIRST} div_mode_t; typedef struct packed {logic [DIV_W-1:0] div; div_mode_t mode;} ch_cfg_t (DIV_W passed via package parameter or fixed localparam).
- Sub-module token_div_channel: one channel holding cfg regs, cnt, hit logic, and b. Top instantiates N_CH copies in a generate loop and decodes cfg_ch into a per-channel write strobe.

Test Plan:
- Reset, ch0 default K=2 LAST, en=1, a[0] = 110_011_101_000_1111 -> b[0] = 010_001_001_000_0101; cnt_o[0] ends 0.
- ch1 write K=3 MODE_FIRST, a[1] = 1111_1111 -> b[1] = 1001_0010; same stream with LAST mode -> b[1] = 0010_0100.
- ch2 write K=0, a[2]=all ones for 10 cycles -> b[2]=0, cnt_o[2]=0. Then write K=1 -> b[2] mirrors a[2].
- ch0 K=4 LAST, three tokens (cnt=3), then a write of K=2 coinciding with the 4th token -> b[0]=1 that cycle (old config), cnt=0 after. Next two tokens -> b = 0,1.
- en=0 for 5 cycles with a=all ones -> b=0 on all channels, cnt_o unchanged. en=1 resumes from the held counts. Write with cfg_ch>=N_CH (N_CH=3 build) -> no channel changes.
- Assert rst_n=0 mid-group with a simultaneous cfg_we -> next cycle all div=DEF_DIV, mode=LAST, cnt=0. Random multi-channel streams checked against a per-channel reference model.

Source files
------------

// File: rtl/token_div_pkg.sv
// rtl/token_div_pkg.sv - shared types for the token divider
package token_div_pkg;

  // Divisor width assumed by the packed configuration record below
  localparam int CFG_DIV_W = 4;

  typedef enum logic {
    MODE_LAST  = 1'b0,
    MODE_FIRST = 1'b1
  } div_mode_t;

  typedef struct packed {
    logic [CFG_DIV_W-1:0] div;
    div_mode_t            mode;
  } ch_cfg_t;

endpackage

// File: rtl/token_div_channel.sv
// rtl/token_div_channel.sv - one channel: config, group counter, pass decision
module token_div_channel
  import token_div_pkg::*;
#(
  parameter int DIV_W   = 4,
  parameter int DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             a,
  input  logic             cfg_we,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_mode,
  output logic             b,
  output logic [DIV_W-1:0] cnt
);

  logic [DIV_W-1:0] div_q;
  div_mode_t        mode_q;
  logic [DIV_W-1:0] cnt_q;

  logic active;
  logic at_end;
  logic hit;

  // A token only counts when enabled and the channel is not blocked (div=0)
  assign active = en & a & (div_q != '0);
  assign at_end = (cnt_q == (div_q - DIV_W'(1)));
  assign hit    = (mode_q == MODE_LAST) ? at_end : (cnt_q == '0);
  assign b      = active & hit;
  assign cnt    = cnt_q;

  // Config write restarts the group and drops a coincident token; reset beats both
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q  <= DIV_W'(DEF_DIV);
      mode_q <= MODE_LAST;
      cnt_q  <= '0;
    end else if (cfg_we) begin
      div_q  <= cfg_div;
      mode_q <= div_mode_t'(cfg_mode);
      cnt_q  <= '0;
    end else if (active) begin
      cnt_q <= at_end ? '0 : cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/token_divider.sv
// rtl/token_divider.sv - multi-channel programmable token rate reducer
module token_divider
  import token_div_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int DIV_W   = 4,
  parameter int DEF_DIV = 2,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [N_CH-1:0]       a,
  output logic [N_CH-1:0]       b,
  input  logic                  cfg_we,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic                  cfg_mode,
  output logic [N_CH*DIV_W-1:0] cnt_o
);

  logic [N_CH-1:0] ch_we;

  // Per-channel write strobe; a select at or beyond N_CH matches no channel
  always_comb begin
    ch_we = '0;
    for (int i = 0; i < N_CH; i++) begin
      ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    token_div_channel #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .a        (a[g]),
      .cfg_we   (ch_we[g]),
      .cfg_div  (cfg_div),
      .cfg_mode (cfg_mode),
      .b        (b[g]),
      .cnt      (cnt_o[g*DIV_W +: DIV_W])
    );
  end

endmodule

// File: tb/tb_token_divider.sv
// tb/tb_token_divider.sv - self-checking bench for token_divider
module tb_token_divider;

  localparam int N_CH    = 3;
  localparam int DIV_W   = 4;
  localparam int DEF_DIV = 2;
  localparam int CH_W    = 2;

  logic                  clk;
  logic                  rst_n;
  logic                  en;
  logic [N_CH-1:0]       a;
  logic [N_CH-1:0]       b;
  logic                  cfg_we;
  logic [CH_W-1:0]       cfg_ch;
  logic [DIV_W-1:0]      cfg_div;
  logic                  cfg_mode;
  logic [N_CH*DIV_W-1:0] cnt_o;

  token_divider #(
    .N_CH    (N_CH),
    .DIV_W   (DIV_W),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .a        (a),
    .b        (b),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_mode (cfg_mode),
    .cnt_o    (cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference: number of counted tokens since the last reset/config write
  int mdiv  [N_CH];
  int mmode [N_CH];
  int mtok  [N_CH];

  typedef struct {
    logic             we;
    logic [CH_W-1:0]  ch;
    logic [DIV_W-1:0] dv;
    logic             md;
    logic [N_CH-1:0]  av;
    logic [N_CH-1:0]  eb;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      mdiv[i] = DEF_DIV; mmode[i] = 0; mtok[i] = 0;
    end
  endtask

  task automatic step(input logic [N_CH-1:0] av, input logic env, input logic rstv,
                      input logic we, input logic [CH_W-1:0] ch,
                      input logic [DIV_W-1:0] dv, input logic md,
                      output logic [N_CH-1:0] bobs);
    logic [N_CH-1:0] eb;
    logic [N_CH*DIV_W-1:0] ec;
    a = av; en = env; rst_n = rstv; cfg_we = we; cfg_ch = ch; cfg_div = dv; cfg_mode = md;
    #2;
    for (int i = 0; i < N_CH; i++) begin
      int ph;
      ph = (mdiv[i] == 0) ? 0 : mtok[i] % mdiv[i];
      eb[i] = env && av[i] && (mdiv[i] != 0) &&
              ((mmode[i] != 0) ? (ph == 0) : (ph == mdiv[i] - 1));
      ec[i*DIV_W +: DIV_W] = DIV_W'(ph);
    end
    chk("b", 32'(b), 32'(eb));
    chk("cnt_o", 32'(cnt_o), 32'(ec));
    bobs = b;
    @(posedge clk);
    if (!rstv) model_reset();
    else begin
      for (int i = 0; i < N_CH; i++) begin
        if (we && int'(ch) == i) begin
          mdiv[i] = int'(dv); mmode[i] = int'(md); mtok[i] = 0;
        end else if (env && av[i] && mdiv[i] != 0) begin
          mtok[i]++;
        end
      end
    end
    #1;
  endtask

  task automatic tk(input logic [N_CH-1:0] av, output logic [N_CH-1:0] bo);
    step(av, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0, bo);
  endtask

  task automatic wr(input logic [CH_W-1:0] ch, input logic [DIV_W-1:0] dv, input logic md);
    logic [N_CH-1:0] bo;
    step('0, 1'b1, 1'b1, 1'b1, ch, dv, md, bo);
  endtask

  task automatic add_stream(input int ch, input int n, input logic [15:0] sa, input logic [15:0] sb);
    for (int i = 0; i < n; i++) begin
      vec_t v;
      v.we = 1'b0; v.ch = '0; v.dv = '0; v.md = 1'b0;
      v.av = N_CH'(sa[n-1-i]) << ch;
      v.eb = N_CH'(sb[n-1-i]) << ch;
      vt.push_back(v);
    end
  endtask

  task automatic add_wr(input int ch, input int dv, input logic md);
    vec_t v;
    v.we = 1'b1; v.ch = CH_W'(ch); v.dv = DIV_W'(dv); v.md = md;
    v.av = '0; v.eb = '0;
    vt.push_back(v);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N_CH-1:0] bo;
    logic [N_CH*DIV_W-1:0] saved;

    a = '0; en = 1'b0; rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    step('0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, bo);
    chk("reset_cnt", 32'(cnt_o), 32'd0);

    // Directed streams: expected b given literally
    add_stream(0, 16, 16'b1100111010001111, 16'b0100010010000101);
    add_wr(1, 3, 1'b1);
    add_stream(1, 8, 16'b11111111, 16'b10010010);
    add_wr(1, 3, 1'b0);
    add_stream(1, 8, 16'b11111111, 16'b00100100);
    add_wr(2, 0, 1'b0);
    add_stream(2, 10, 16'b1111111111, 16'b0000000000);
    add_wr(2, 1, 1'b0);
    add_stream(2, 6, 16'b101101, 16'b101101);
    foreach (vt[k]) begin
      step(vt[k].av, 1'b1, 1'b1, vt[k].we, vt[k].ch, vt[k].dv, vt[k].md, bo);
      chk($sformatf("table[%0d]", k), 32'(bo), 32'(vt[k].eb));
    end
    chk("ch0_end_cnt", 32'(cnt_o[0 +: DIV_W]), 32'd0);

    // Write coinciding with a token: old config decides b, token dropped
    wr(0, 4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tk(3'b001, bo);
      chk("k4_pre", 32'(bo[0]), 32'd0);
    end
    chk("k4_cnt3", 32'(cnt_o[0 +: DIV_W]), 32'd3);
    step(3'b001, 1'b1, 1'b1, 1'b1, 2'd0, 4'd2, 1'b0, bo);
    chk("wr_tok_b", 32'(bo[0]), 32'd1);
    chk("wr_tok_cnt", 32'(cnt_o[0 +: DIV_W]), 32'd0);
    tk(3'b001, bo);
    chk("after_wr_1", 32'(bo[0]), 32'd0);
    tk(3'b001, bo);
    chk("after_wr_2", 32'(bo[0]), 32'd1);

    // Enable low holds counts; out-of-range write is ignored
    wr(0, 3, 1'b0);
    tk(3'b001, bo);
    wr(1, 5, 1'b1);
    tk(3'b010, bo);
    tk(3'b010, bo);
    saved = cnt_o;
    for (int i = 0; i < 5; i++) begin
      step(3'b111, 1'b0, 1'b1, (i == 2), 2'd3, 4'd7, 1'b1, bo);
      chk("en0_b", 32'(bo), 32'd0);
    end
    chk("en0_hold", 32'(cnt_o), 32'(saved));
    chk("en0_cnts", 32'(cnt_o), 32'h021);
    tk(3'b111, bo);
    chk("resume", 32'(bo), 32'b100);

    // Reset mid-group beats a simultaneous config write
    tk(3'b011, bo);
    step(3'b111, 1'b1, 1'b0, 1'b1, 2'd0, 4'd5, 1'b1, bo);
    chk("rst_cnt", 32'(cnt_o), 32'd0);
    tk(3'b111, bo);
    chk("rst_def_1", 32'(bo), 32'b000);
    tk(3'b111, bo);
    chk("rst_def_2", 32'(bo), 32'b111);

    // Random traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      logic [DIV_W-1:0] dv;
      dv = ($urandom_range(0, 9) == 0) ? DIV_W'($urandom_range(0, 15)) : DIV_W'($urandom_range(0, 5));
      step(N_CH'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 149) != 0),
           ($urandom_range(0, 7) == 0), CH_W'($urandom_range(0, 3)), dv,
           1'($urandom_range(0, 1)), bo);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
